// File: rtl/spi_fifo_tx.sv
// SPI mode-0 transmitter that drains a FIFO read port and sends its bytes MSB first.
// Consecutive bytes go out back-to-back inside a chip-select frame of up to BURST_LEN bytes.
module spi_fifo_tx #(
  parameter int DSIZE     = 8,
  parameter int CLK_DIV   = 4,
  parameter int BURST_LEN = 16,
  parameter int CS_GAP    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DSIZE-1:0] fifo_rdata,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  output logic             spi_sck,
  output logic             spi_mosi,
  output logic             spi_cs_n,
  output logic             busy,
  output logic             frame_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(2 * DSIZE);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TOG_LAST  = TW'(2 * DSIZE - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  state_t           state, state_nxt;
  logic [DSIZE-1:0] shreg, shreg_nxt;
  logic [DW-1:0]    div_cnt, div_cnt_nxt;
  logic [TW-1:0]    tog_cnt, tog_cnt_nxt;
  logic [BW-1:0]    byte_cnt, byte_cnt_nxt;
  logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
  logic             sck_nxt, mosi_nxt, cs_n_nxt, busy_nxt, frame_done_nxt;

  logic tick, last_tog, can_load, chain_load;

  assign tick       = (div_cnt == DIV_LAST);
  assign last_tog   = (tog_cnt == TOG_LAST);
  assign can_load   = enable && !fifo_rempty;
  assign chain_load = can_load && (byte_cnt < BURST_MAX);

  // The pop strobe marks exactly the edge that captures fifo_rdata; it is held off during reset.
  assign fifo_rinc = !rst && (((state == IDLE) && can_load) ||
                              ((state == SHIFT) && tick && last_tog && chain_load));

  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    div_cnt_nxt    = div_cnt;
    tog_cnt_nxt    = tog_cnt;
    byte_cnt_nxt   = byte_cnt;
    gap_cnt_nxt    = gap_cnt;
    sck_nxt        = spi_sck;
    mosi_nxt       = spi_mosi;
    cs_n_nxt       = spi_cs_n;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (can_load) begin
          state_nxt    = SHIFT;
          shreg_nxt    = fifo_rdata;
          mosi_nxt     = fifo_rdata[DSIZE-1];
          cs_n_nxt     = 1'b0;
          busy_nxt     = 1'b1;
          byte_cnt_nxt = BW'(1);
          div_cnt_nxt  = '0;
          tog_cnt_nxt  = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          div_cnt_nxt = '0;
          sck_nxt     = !spi_sck;
          if (last_tog) begin
            tog_cnt_nxt = '0;
            if (chain_load) begin
              shreg_nxt    = fifo_rdata;
              mosi_nxt     = fifo_rdata[DSIZE-1];
              byte_cnt_nxt = byte_cnt + BW'(1);
            end else begin
              state_nxt = HOLD;
            end
          end else begin
            tog_cnt_nxt = tog_cnt + TW'(1);
            // Falling SCK edge: present the next bit so it is stable at the next rise.
            if (spi_sck) begin
              shreg_nxt = shreg << 1;
              mosi_nxt  = shreg_nxt[DSIZE-1];
            end
          end
        end else begin
          div_cnt_nxt = div_cnt + DW'(1);
        end
      end
      HOLD: begin
        if (tick) begin
          state_nxt      = GAP;
          div_cnt_nxt    = '0;
          gap_cnt_nxt    = '0;
          cs_n_nxt       = 1'b1;
          mosi_nxt       = 1'b0;
          frame_done_nxt = 1'b1;
        end else begin
          div_cnt_nxt = div_cnt + DW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
          busy_nxt    = 1'b0;
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      div_cnt    <= '0;
      tog_cnt    <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      div_cnt    <= div_cnt_nxt;
      tog_cnt    <= tog_cnt_nxt;
      byte_cnt   <= byte_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      spi_sck    <= sck_nxt;
      spi_mosi   <= mosi_nxt;
      spi_cs_n   <= cs_n_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule
